// File: rtl/lif_spike_gen.sv
// Spike generator for a leaky integrate-and-fire neuron: adaptive threshold,
// refractory hold-off, integrator reset request and a saturating spike counter.
module lif_spike_gen #(
  parameter int WIDTH         = 8,
  parameter int REFRAC_CYCLES = 4,
  parameter int THRESH_INC    = 16,
  parameter int DECAY_SHIFT   = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     state,
  input  logic [WIDTH-1:0]     threshold_base,
  input  logic                 enable,
  input  logic                 clear_count,
  output logic                 spike,
  output logic                 hold_reset,
  output logic                 refractory,
  output logic [WIDTH-1:0]     threshold,
  output logic [CNT_WIDTH-1:0] spike_count
);

  localparam int RC_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic [WIDTH:0]     THR_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]     THR_INC = (WIDTH+1)'(THRESH_INC);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    FIRE      = 2'd1,
    REFRAC    = 2'd2
  } fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [RC_W-1:0]      rc_q, rc_d;
  logic [WIDTH-1:0]     thr_q, thr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 spike_q, spike_d;
  logic                 refr_q, refr_d;
  logic                 hold_q, hold_d;

  logic [WIDTH:0]       thr_sum, thr_diff, thr_step, thr_decay, thr_inc;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 fire_exit;

  always_comb begin
    fsm_d     = fsm_q;
    rc_d      = rc_q;
    fire_exit = 1'b0;

    // Decay moves by at least one step so the threshold lands exactly on base.
    thr_sum  = {1'b0, thr_q} + THR_INC;
    thr_diff = {1'b0, thr_q} - {1'b0, threshold_base};
    if ((thr_diff >> DECAY_SHIFT) == '0) begin
      thr_step = (WIDTH+1)'(1);
    end else begin
      thr_step = thr_diff >> DECAY_SHIFT;
    end
    if (thr_q > threshold_base) begin
      thr_decay = {1'b0, thr_q} - thr_step;
    end else begin
      thr_decay = {1'b0, threshold_base};
    end
    if (thr_sum > THR_MAX) begin
      thr_inc = THR_MAX;
    end else begin
      thr_inc = thr_sum;
    end
    thr_d = thr_decay[WIDTH-1:0];

    case (fsm_q)
      INTEGRATE: begin
        if (enable && (state >= thr_q)) begin
          fsm_d = FIRE;
        end else begin
          fsm_d = INTEGRATE;
        end
      end
      FIRE: begin
        thr_d     = thr_inc[WIDTH-1:0];
        fire_exit = 1'b1;
        if (REFRAC_CYCLES == 0) begin
          fsm_d = INTEGRATE;
          rc_d  = '0;
        end else begin
          fsm_d = REFRAC;
          rc_d  = RC_W'(REFRAC_CYCLES);
        end
      end
      REFRAC: begin
        if (rc_q <= RC_W'(1)) begin
          fsm_d = INTEGRATE;
          rc_d  = '0;
        end else begin
          fsm_d = REFRAC;
          rc_d  = rc_q - RC_W'(1);
        end
      end
      default: begin
        fsm_d = INTEGRATE;
        rc_d  = '0;
      end
    endcase

    if (cnt_q == CNT_MAX) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + CNT_WIDTH'(1);
    end
    // A clear that coincides with a spike keeps that spike.
    if (clear_count) begin
      cnt_d = fire_exit ? CNT_WIDTH'(1) : '0;
    end else if (fire_exit) begin
      cnt_d = cnt_inc;
    end else begin
      cnt_d = cnt_q;
    end

    spike_d = (fsm_d == FIRE);
    refr_d  = (fsm_d == REFRAC);
    hold_d  = spike_d | refr_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q   <= INTEGRATE;
      rc_q    <= '0;
      thr_q   <= threshold_base;
      cnt_q   <= '0;
      spike_q <= 1'b0;
      refr_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
      refr_q  <= refr_d;
      hold_q  <= hold_d;
    end
  end

  assign spike       = spike_q;
  assign refractory  = refr_q;
  assign hold_reset  = hold_q;
  assign threshold   = thr_q;
  assign spike_count = cnt_q;

endmodule
